// File: rtl/alu_mdu.sv
// alu_mdu: iterative radix-2 RV32M multiply/divide unit; divider built only when ALU_MDU_DIV_EN is defined
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_div_by_zero,
  output logic             o_illegal
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op;
  logic [WIDTH-1:0] mag_a, mag_b, in_mag_a, in_mag_b, mul_res, result_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH:0] mul_sum;
  logic neg_res, a_sgn, b_sgn, sa, sb, accept, fast;
`ifdef ALU_MDU_DIV_EN
  logic [WIDTH-1:0] raw_a, quo, rem, div_res;
  logic [WIDTH:0] shifted, diff;
  logic rem_neg, dz, ovf, in_dz, in_ovf, ge;
`else
  logic ill;
`endif
  always_comb begin
    accept = state == IDLE && i_valid && !i_flush;
    a_sgn = i_funct3[2] ? !i_funct3[0] : ^i_funct3[1:0];
    b_sgn = i_funct3[2] ? !i_funct3[0] : (i_funct3[1:0] == 2'b01);
    sa = a_sgn & i_operand_a[WIDTH-1];
    sb = b_sgn & i_operand_b[WIDTH-1];
    in_mag_a = sa ? -i_operand_a : i_operand_a;
    in_mag_b = sb ? -i_operand_b : i_operand_b;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a & {WIDTH{acc[0]}}};
    prod = neg_res ? -acc : acc;
    mul_res = op == 3'b000 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_DIV_EN
    in_dz = i_funct3[2] && i_operand_b == '0;
    in_ovf = i_funct3[2] && !i_funct3[0] && i_operand_a == {1'b1, {(WIDTH-1){1'b0}}} && &i_operand_b;
    fast = in_dz || in_ovf;
    // restoring step: the W+1-bit trial difference's sign bit says whether the divisor fits
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = shifted - {1'b0, mag_b};
    ge = !diff[WIDTH];
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    div_res = op[1] ? (rem_neg ? -rem : rem) : (neg_res ? -quo : quo);
    acc_nx = op[2] ? {ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc[WIDTH-2:0], ge}
                   : {mul_sum, acc[WIDTH-1:1]};
    result_nx = dz ? (op[1] ? raw_a : '1) : ovf ? (op[1] ? '0 : raw_a) : op[2] ? div_res : mul_res;
`else
    fast = i_funct3[2];
    acc_nx = {mul_sum, acc[WIDTH-1:1]};
    result_nx = ill ? '0 : mul_res;
`endif
    state_nx = i_flush ? IDLE :
               state == IDLE ? (i_valid ? (fast ? FIX : CALC) : IDLE) :
               state == CALC ? (cnt == CNT_W'(1) ? FIX : CALC) :
               state == FIX  ? DONE : (i_ready ? IDLE : DONE);
    o_ready = state == IDLE;
    o_valid = state == DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      mag_a <= '0;
      mag_b <= '0;
      neg_res <= 1'b0;
      acc <= '0;
      o_result <= '0;
      o_div_by_zero <= 1'b0;
      o_illegal <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      raw_a <= '0;
      rem_neg <= 1'b0;
      dz <= 1'b0;
      ovf <= 1'b0;
`else
      ill <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        op <= i_funct3;
        mag_a <= in_mag_a;
        mag_b <= in_mag_b;
        neg_res <= sa ^ sb;
        cnt <= CNT_W'(WIDTH);
        acc <= {{WIDTH{1'b0}}, i_funct3[2] ? in_mag_a : in_mag_b};
`ifdef ALU_MDU_DIV_EN
        raw_a <= i_operand_a;
        rem_neg <= sa;
        dz <= in_dz;
        ovf <= in_ovf;
`else
        ill <= i_funct3[2];
`endif
      end
      if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt - CNT_W'(1);
      end
      if (state == FIX) begin
        o_result <= result_nx;
`ifdef ALU_MDU_DIV_EN
        o_div_by_zero <= dz;
        o_illegal <= 1'b0;
`else
        o_div_by_zero <= 1'b0;
        o_illegal <= ill;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32
module tb_alu_mdu;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b0;
  logic [2:0] i_funct3 = '0;
  logic [31:0] i_operand_a = '0, i_operand_b = '0;
  logic o_ready, o_valid, o_div_by_zero, o_illegal;
  logic [31:0] o_result;
  int passed = 0, total = 0;

  alu_mdu dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_funct3(i_funct3), .i_operand_a(i_operand_a), .i_operand_b(i_operand_b),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_div_by_zero(o_div_by_zero), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // present one op, let it be accepted, scramble operands, count edges until o_valid
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, output int cyc);
    i_funct3 = f;
    i_operand_a = a;
    i_operand_b = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    i_operand_a = 32'hDEADBEEF;
    i_operand_b = 32'h0BADF00D;
    i_funct3 = ~f;
    cyc = 0;
    while (!o_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    total++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", o_valid); else passed++;
    total++; if (o_result !== 32'h0) $display("FAIL reset_result got %h want 0", o_result); else passed++;
    total++; if (o_div_by_zero !== 1'b0) $display("FAIL reset_dz got %b want 0", o_div_by_zero); else passed++;
    total++; if (o_illegal !== 1'b0) $display("FAIL reset_ill got %b want 0", o_illegal); else passed++;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    logic [2:0] f [7] = '{3'b001, 3'b000, 3'b011, 3'b010, 3'b010, 3'b001, 3'b000};
    logic [31:0] a [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h80000000, 32'd6};
    logic [31:0] b [7] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'hFFFFFFFF, 32'h80000000, 32'd7};
    logic [31:0] e [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h2, 32'hFFFFFFFF, 32'h1, 32'h40000000, 32'd42};
    for (int i = 0; i < 7; i++) begin
      run_op(f[i], a[i], b[i], cyc);
      total++; if (cyc !== 33) $display("FAIL mul%0d_latency got %0d want 33", i, cyc); else passed++;
      total++; if (o_result !== e[i]) $display("FAIL mul%0d_result got %h want %h", i, o_result, e[i]); else passed++;
      total++; if (o_illegal !== 1'b0 || o_div_by_zero !== 1'b0) $display("FAIL mul%0d_flags got %b%b want 00", i, o_illegal, o_div_by_zero); else passed++;
      take();
    end
  endtask

  task automatic test_div();
    int cyc;
    logic [2:0] f [6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] a [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] b [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
`ifdef ALU_MDU_DIV_EN
    logic [31:0] e [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    int lat = 33;
    logic ill = 1'b0;
`else
    logic [31:0] e [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    int lat = 1;
    logic ill = 1'b1;
`endif
    for (int i = 0; i < 6; i++) begin
      run_op(f[i], a[i], b[i], cyc);
      total++; if (cyc !== lat) $display("FAIL div%0d_latency got %0d want %0d", i, cyc, lat); else passed++;
      total++; if (o_result !== e[i]) $display("FAIL div%0d_result got %h want %h", i, o_result, e[i]); else passed++;
      total++; if (o_illegal !== ill) $display("FAIL div%0d_illegal got %b want %b", i, o_illegal, ill); else passed++;
      take();
    end
  endtask

  task automatic test_special();
    int cyc;
    logic [2:0] f [4] = '{3'b101, 3'b110, 3'b100, 3'b110};
    logic [31:0] a [4] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000};
    logic [31:0] b [4] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef ALU_MDU_DIV_EN
    logic [31:0] e [4] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0};
    logic dz [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    logic [31:0] e [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic dz [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], a[i], b[i], cyc);
      total++; if (cyc !== 1) $display("FAIL spc%0d_latency got %0d want 1", i, cyc); else passed++;
      total++; if (o_result !== e[i]) $display("FAIL spc%0d_result got %h want %h", i, o_result, e[i]); else passed++;
      total++; if (o_div_by_zero !== dz[i]) $display("FAIL spc%0d_dz got %b want %b", i, o_div_by_zero, dz[i]); else passed++;
      take();
    end
  endtask

  task automatic test_flush();
    int cyc;
    logic seen = 1'b0;
    i_valid = 1'b1;
    i_flush = 1'b1;
    i_funct3 = 3'b000;
    tick();
    i_valid = 1'b0;
    i_flush = 1'b0;
    total++; if (o_ready !== 1'b1) $display("FAIL flush_beats_valid got ready %b want 1", o_ready); else passed++;
    i_funct3 = 3'b011;
    i_operand_a = 32'h12345678;
    i_operand_b = 32'h9ABCDEF0;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    total++; if (o_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", o_ready); else passed++;
    for (int i = 0; i < 40; i++) begin
      seen = seen | o_valid;
      tick();
    end
    total++; if (seen !== 1'b0) $display("FAIL flush_no_valid got %b want 0", seen); else passed++;
    run_op(3'b000, 32'd6, 32'd7, cyc);
    total++; if (o_result !== 32'd42) $display("FAIL flush_next_result got %h want %h", o_result, 32'd42); else passed++;
    take();
  endtask

  task automatic test_reset_mid();
    i_funct3 = 3'b011;
    i_operand_a = 32'hFFFFFFFF;
    i_operand_b = 32'hFFFFFFFF;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    i_rst_n = 1'b0;
    #1;
    total++; if (o_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", o_ready); else passed++;
    total++; if (o_result !== 32'h0) $display("FAIL rstmid_result got %h want 0", o_result); else passed++;
    total++; if (o_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", o_valid); else passed++;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(3'b000, 32'd6, 32'd7, cyc);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (o_result !== 32'd42 || o_valid !== 1'b1) $display("FAIL hold%0d got %h/%b want %h/1", i, o_result, o_valid, 32'd42); else passed++;
      total++; if (o_ready !== 1'b0) $display("FAIL hold%0d_ready got %b want 0", i, o_ready); else passed++;
    end
    take();
    total++; if (o_ready !== 1'b1 || o_valid !== 1'b0) $display("FAIL handoff got ready %b valid %b want 1 0", o_ready, o_valid); else passed++;
    run_op(3'b011, 32'h10000, 32'h10000, cyc);
    total++; if (o_result !== 32'h1 || cyc !== 33) $display("FAIL b2b got %h in %0d want 00000001 in 33", o_result, cyc); else passed++;
    take();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
